sort_batch_sequencer: RTL and testbench
=======================================

Name: sort_batch_sequencer

Overview:
- Initiator side of the 4-entry sorter load/sort/result interface.
- Accepts a valid/ready stream of four W-bit elements and loads them into the sorter one at a time via sel/dataIn.
- Asserts sort, waits for done, captures the four sorted results, and streams them out on a valid/ready port in A, B, C, D order.
- Sits between a stream source (UART/switch front-end) and the sorter core.

Parameters:
W, 4, element width in bits.
LOAD_HOLD, 2, cycles each element is held on sel/dataIn (at least 1).
TIMEOUT, 64, max cycles in WAIT_DONE before abort (at least 2).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-low reset.
in_data  in  W  incoming element.
in_valid  in  1  in_data valid.
in_ready  out  1  sequencer can accept an element.
out_data  out  W  sorted element.
out_valid  out  1  out_data valid.
out_ready  in  1  sink accepts out_data.
out_last  out  1  marks the 4th (D) output element.
sort_clr  out  1  one-cycle active-high clear to the sorter.
sel  out  2  sorter element select.
dataIn  out  W  sorter element data.
sort  out  1  sorter start; level-held.
Aout, Bout, Cout, Dout  in  W each  sorter results.
done  in  1  sorter complete (level).
busy  out  1  high in every state except IDLE.
timeout_err  out  1  sticky abort flag.

Behaviour:
Reset (rst low, async):
- State goes to IDLE.
- All outputs are 0: in_ready, out_valid, out_last, out_data, sort_clr, sel, dataIn, sort, busy.
- timeout_err is cleared. All counters and the capture registers are cleared.

States: IDLE, LOAD, HOLD, SORT, WAIT_DONE, UNLOAD.

IDLE:
- in_ready is 1.
- On in_valid and in_ready:
  - Register in_data into dataIn and set sel to 0.
  - Pulse sort_clr for exactly this one cycle.
  - Clear timeout_err, set the element index to 1, and go to HOLD.

HOLD:
- in_ready is 0; sel and dataIn are stable.
- Count LOAD_HOLD cycles.
- When the count expires: if index equals 4, go to SORT; otherwise go to LOAD.

LOAD:
- in_ready is 1; sel and dataIn keep their previous values.
- On handshake: dataIn takes in_data, sel takes the index, the index increments, and the state goes to HOLD.
- Gaps in in_valid are allowed indefinitely.

SORT:
- Set sort to 1, keeping sel at 3 and dataIn at the last element.
- Clear the timeout counter and go to WAIT_DONE the next cycle.
- done is never sampled in the same cycle sort first rises.

WAIT_DONE:
- sort is held at 1 and the timeout counter increments each cycle.
- If done is 1: capture Aout through Dout into the result registers, set sort to 0, and go to UNLOAD.
- Else, if the counter reaches TIMEOUT-1: set timeout_err to 1, set sort to 0, and go to IDLE with no output produced.
- done takes priority over timeout in the same cycle.

UNLOAD:
- out_valid is 1 and out_data is result[k], for k = 0 to 3 (A, B, C, D).
- out_last is 1 only when k equals 3.
- On out_valid and out_ready, k increments; after k=3 is accepted, go to IDLE with out_valid at 0.
- While out_ready is 0, out_data, out_last and out_valid are held stable.
- Results are registered copies, so sorter activity after capture does not affect the stream.

General rules:
- in_ready is 0 in HOLD, SORT, WAIT_DONE and UNLOAD; no new batch overlaps an unload.
- sort_clr pulses only at the first element of a batch.
- The sorter's done from a prior batch is therefore cleared before the new sort.
- The sequencer does no arithmetic on data and passes values unmodified.
- The index and k are 2-bit wrap-free counters bounded by the state machine.
- Reset asserted mid-batch (any state) aborts immediately. After rst is released, the block is in IDLE; a new batch must restart at element 0.
- timeout_err stays high until the next batch's first handshake or reset.

Test Plan:
- Load in 4, 3, 2, 1 back-to-back with LOAD_HOLD=2. Expect one sort_clr pulse and sel sequence 0, 1, 2, 3, each held 2 cycles. sort rises after the 4th hold. The model sorter raises done after 20 cycles with A=1, B=2, C=3, D=4. Expect out stream 1, 2, 3, 4 with out_last only on 4 and sort low after capture.
- Load in 9, 7, 15, 12 with 3-cycle in_valid gaps between elements. Expect sel/dataIn values 0/9, 1/7, 2/15, 3/12 in order, no extra elements accepted, and output 7, 9, 12, 15.
- Hold out_ready at 0 for 5 cycles on each output element of 15, 13, 8, 1 (sorted 1, 8, 13, 15). Expect out_data and out_last stable during the stall and exactly four handshakes. in_ready stays 0 until after the handshake for 15.
- Model sorter never asserts done, with TIMEOUT=64. Expect sort high for exactly 64 cycles, then timeout_err=1 and the state back in IDLE with out_valid never asserted. A following valid batch clears timeout_err on its first handshake and completes normally.
- Assert rst low in WAIT_DONE, and separately in UNLOAD after 2 outputs. Expect sort, out_valid, busy, sel and dataIn to go to 0 asynchronously. A following batch of 4, 3, 2, 1 produces 1, 2, 3, 4 correctly.
- done already high from the model before SORT. Expect the sort_clr pulse at the start of the batch to clear it in the model, and no capture occurring before sort has been high at least one cycle.

Source files
------------

// File: rtl/sort_batch_sequencer.sv
// Loads four elements into a 4-entry sorter, starts it, then streams the captured results out in A..D order.
// Outputs are registered; in_ready stays low from the last load until the final result is accepted, and out_* hold while out_ready is low.
module sort_batch_sequencer #(
    parameter int W         = 4,
    parameter int LOAD_HOLD = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         sort_clr,
    output logic [1:0]   sel,
    output logic [W-1:0] dataIn,
    output logic         sort,
    input  logic [W-1:0] Aout,
    input  logic [W-1:0] Bout,
    input  logic [W-1:0] Cout,
    input  logic [W-1:0] Dout,
    input  logic         done,
    output logic         busy,
    output logic         timeout_err
);

    localparam int HCW = (LOAD_HOLD > 1) ? $clog2(LOAD_HOLD) : 1;
    localparam int TCW = $clog2(TIMEOUT);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(LOAD_HOLD - 1);
    localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_SORT,
        ST_WAIT_DONE,
        ST_UNLOAD
    } state_t;

    state_t         state_q;
    logic [HCW-1:0] hcnt_q;
    logic [TCW-1:0] tcnt_q;
    logic [1:0]     idx_q;
    logic [1:0]     k_q;
    logic [W-1:0]   res_q [4];
    logic           in_ready_q;
    logic [W-1:0]   out_data_q;
    logic           out_valid_q;
    logic           out_last_q;
    logic           sort_clr_q;
    logic [1:0]     sel_q;
    logic [W-1:0]   data_in_q;
    logic           sort_q;
    logic           timeout_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            hcnt_q        <= '0;
            tcnt_q        <= '0;
            idx_q         <= '0;
            k_q           <= '0;
            for (int i = 0; i < 4; i++) res_q[i] <= '0;
            in_ready_q    <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            sort_clr_q    <= 1'b0;
            sel_q         <= '0;
            data_in_q     <= '0;
            sort_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            sort_clr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        data_in_q     <= in_data;
                        sel_q         <= 2'd0;
                        sort_clr_q    <= 1'b1;
                        timeout_err_q <= 1'b0;
                        idx_q         <= 2'd1;
                        hcnt_q        <= '0;
                        in_ready_q    <= 1'b0;
                        state_q       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hcnt_q == HOLD_LAST) begin
                        hcnt_q <= '0;
                        // sel of 3 means the fourth element has just been held
                        if (sel_q == 2'd3) begin
                            state_q <= ST_SORT;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= ST_LOAD;
                        end
                    end else begin
                        hcnt_q <= hcnt_q + HCW'(1);
                    end
                end
                ST_LOAD: begin
                    if (in_valid && in_ready_q) begin
                        data_in_q  <= in_data;
                        sel_q      <= idx_q;
                        idx_q      <= idx_q + 2'd1;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_HOLD;
                    end
                end
                ST_SORT: begin
                    sort_q  <= 1'b1;
                    tcnt_q  <= '0;
                    state_q <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (done) begin
                        res_q[0]    <= Aout;
                        res_q[1]    <= Bout;
                        res_q[2]    <= Cout;
                        res_q[3]    <= Dout;
                        out_data_q  <= Aout;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        k_q         <= 2'd0;
                        sort_q      <= 1'b0;
                        state_q     <= ST_UNLOAD;
                    end else if (tcnt_q == TMO_LAST) begin
                        timeout_err_q <= 1'b1;
                        sort_q        <= 1'b0;
                        in_ready_q    <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + TCW'(1);
                    end
                end
                ST_UNLOAD: begin
                    if (out_ready) begin
                        if (k_q == 2'd3) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_data_q  <= '0;
                            in_ready_q  <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            k_q        <= k_q + 2'd1;
                            out_data_q <= res_q[k_q + 2'd1];
                            out_last_q <= (k_q == 2'd2);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign sort_clr    = sort_clr_q;
    assign sel         = sel_q;
    assign dataIn      = data_in_q;
    assign sort        = sort_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sort_batch_sequencer.sv
// Directed bench with a behavioural 4-entry sorter and scoreboards for the load sequence and the result stream.
module tb_sort_batch_sequencer;

    localparam int W   = 4;
    localparam int LH  = 2;
    localparam int TMO = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_last;
    logic         sort_clr;
    logic [1:0]   sel;
    logic [W-1:0] dataIn;
    logic         sort;
    logic [W-1:0] m_a = '0, m_b = '0, m_c = '0, m_d = '0;
    logic         m_done = 1'b0;
    logic         busy;
    logic         timeout_err;

    always #5 clk = ~clk;

    sort_batch_sequencer #(.W(W), .LOAD_HOLD(LH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .sort_clr(sort_clr), .sel(sel), .dataIn(dataIn), .sort(sort),
        .Aout(m_a), .Bout(m_b), .Cout(m_c), .Dout(m_d), .done(m_done),
        .busy(busy), .timeout_err(timeout_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*W-1:0] sort4(input logic [W-1:0] a, b, c, d);
        logic [W-1:0] v[4];
        logic [W-1:0] t;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
                if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // Behavioural sorter: latches sel/dataIn while loading, raises done 20 cycles into sort.
    logic [W-1:0] m_mem[4] = '{default: '0};
    int           m_cnt = 0;
    logic         m_never = 1'b0;
    logic         m_preset = 1'b0;

    always @(posedge clk) begin
        logic [4*W-1:0] s;
        s = sort4(m_mem[0], m_mem[1], m_mem[2], m_mem[3]);
        if (busy && !sort) m_mem[sel] <= dataIn;
        if (m_preset) begin
            m_done <= 1'b1;
            m_a <= '1; m_b <= '1; m_c <= '1; m_d <= '1;
        end else if (sort_clr) begin
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else if (sort && !m_done && !m_never) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 19) begin
                m_done <= 1'b1;
                m_a <= s[4*W-1 -: W]; m_b <= s[3*W-1 -: W];
                m_c <= s[2*W-1 -: W]; m_d <= s[W-1:0];
            end
        end else if (!sort) begin
            m_cnt <= 0;
        end
    end

    logic [W:0]   exp_out_q[$];
    logic [W+1:0] exp_load_q[$];
    int   clr_cnt = 0, hs_cnt = 0, vld_cnt = 0;
    int   sort_run = 0, last_sort_run = 0, ld_run = 0;
    logic prev_sort = 1'b0;
    logic [1:0] last_sel = '0;

    always @(negedge clk) begin
        logic [W:0]   eo;
        logic [W+1:0] el;
        if (sort_clr) clr_cnt++;
        if (sort && !prev_sort) chk("done_low_at_sort_rise", m_done, 0);
        if (sort) sort_run++;
        else if (prev_sort) begin last_sort_run = sort_run; sort_run = 0; end
        prev_sort = sort;
        if (busy && !sort && (sort_clr || sel != last_sel)) begin
            if (!sort_clr) chk("sel_hold_len_ok", ld_run >= LH, 1);
            chk("load_expected", exp_load_q.size() != 0, 1);
            if (exp_load_q.size() != 0) begin
                el = exp_load_q.pop_front();
                chk("load_sel_dataIn", {sel, dataIn}, el);
            end
            ld_run = 1;
        end else if (busy) begin
            ld_run++;
        end
        last_sel = sel;
        if (out_valid) begin
            vld_cnt++;
            chk("sort_low_in_unload", sort, 0);
        end
        if (out_valid && out_ready) begin
            hs_cnt++;
            chk("out_expected", exp_out_q.size() != 0, 1);
            if (exp_out_q.size() != 0) begin
                eo = exp_out_q.pop_front();
                chk("out_data", out_data, eo[W-1:0]);
                chk("out_last", out_last, eo[W]);
            end
        end
    end

    task automatic send_batch(input logic [W-1:0] e0, e1, e2, e3, input int gap, input bit expect_out);
        logic [W-1:0]   e[4];
        logic [4*W-1:0] s;
        int             t;
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) exp_load_q.push_back({2'(i), e[i]});
        if (expect_out) begin
            s = sort4(e0, e1, e2, e3);
            exp_out_q.push_back({1'b0, s[4*W-1 -: W]});
            exp_out_q.push_back({1'b0, s[3*W-1 -: W]});
            exp_out_q.push_back({1'b0, s[2*W-1 -: W]});
            exp_out_q.push_back({1'b1, s[W-1:0]});
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = e[i];
            t = 0;
            do begin @(negedge clk); t++; end while (!in_ready && t < 200);
            chk("in_ready_within_bound", in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (i == 0) chk("timeout_err_cleared_on_first", timeout_err, 0);
            repeat (gap) @(posedge clk);
        end
    endtask

    task automatic wait_batch(input int bound);
        int t = 0;
        while ((busy || exp_out_q.size() != 0) && t < bound) begin @(negedge clk); t++; end
        chk("batch_complete_within_bound", busy || exp_out_q.size() != 0, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int t, base_clr, base_hs, base_vld;

        repeat (3) @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sort_clr", sort_clr, 0);
        chk("rst_sel", sel, 0);
        chk("rst_dataIn", dataIn, 0);
        chk("rst_sort", sort, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst = 1'b1;

        // Back-to-back load.
        base_clr = clr_cnt; base_hs = hs_cnt;
        send_batch(4'd4, 4'd3, 4'd2, 4'd1, 0, 1'b1);
        wait_batch(400);
        chk("t1_one_sort_clr", clr_cnt - base_clr, 1);
        chk("t1_four_outputs", hs_cnt - base_hs, 4);

        // Gapped input stream.
        base_clr = clr_cnt; base_hs = hs_cnt;
        send_batch(4'd9, 4'd7, 4'd15, 4'd12, 3, 1'b1);
        wait_batch(400);
        chk("t2_one_sort_clr", clr_cnt - base_clr, 1);
        chk("t2_four_outputs", hs_cnt - base_hs, 4);
        chk("t2_no_extra_loads", exp_load_q.size(), 0);

        // Output backpressure: five stall cycles per element.
        out_ready = 1'b0;
        base_hs = hs_cnt;
        send_batch(4'd15, 4'd13, 4'd8, 4'd1, 0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            t = 0;
            do begin @(negedge clk); t++; end while (!out_valid && t < 200);
            chk("t3_valid_within_bound", out_valid, 1);
            repeat (5) begin
                @(negedge clk);
                chk("t3_stall_valid", out_valid, 1);
                chk("t3_stall_data", out_data, exp_out_q[0][W-1:0]);
                chk("t3_stall_last", out_last, exp_out_q[0][W]);
                chk("t3_stall_in_ready", in_ready, 0);
            end
            @(posedge clk); #1 out_ready = 1'b1;
            @(posedge clk); #1 out_ready = 1'b0;
        end
        @(negedge clk);
        chk("t3_in_ready_after_last", in_ready, 1);
        chk("t3_four_handshakes", hs_cnt - base_hs, 4);
        out_ready = 1'b1;

        // Sorter never completes.
        m_never = 1'b1;
        base_vld = vld_cnt;
        send_batch(4'd5, 4'd1, 4'd3, 4'd2, 0, 1'b0);
        wait_batch(300);
        chk("t4_timeout_err_set", timeout_err, 1);
        chk("t4_sort_high_cycles", last_sort_run, TMO);
        chk("t4_no_output", vld_cnt - base_vld, 0);
        chk("t4_back_idle", busy, 0);
        m_never = 1'b0;
        send_batch(4'd5, 4'd1, 4'd3, 4'd2, 0, 1'b1);
        wait_batch(400);
        chk("t4_recovered_err_low", timeout_err, 0);

        // Reset during WAIT_DONE.
        send_batch(4'd4, 4'd3, 4'd2, 4'd1, 0, 1'b0);
        t = 0;
        do begin @(posedge clk); #2; t++; end while (!sort && t < 100);
        chk("t5_sort_seen", sort, 1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t5_async_sort", sort, 0);
        chk("t5_async_out_valid", out_valid, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_sel", sel, 0);
        chk("t5_async_dataIn", dataIn, 0);
        @(posedge clk); #1 rst = 1'b1;
        send_batch(4'd4, 4'd3, 4'd2, 4'd1, 0, 1'b1);
        wait_batch(400);

        // Reset in UNLOAD after two outputs.
        base_hs = hs_cnt;
        send_batch(4'd4, 4'd3, 4'd2, 4'd1, 0, 1'b1);
        t = 0;
        do begin @(posedge clk); #2; t++; end while (hs_cnt - base_hs < 2 && t < 300);
        chk("t5b_two_outputs", hs_cnt - base_hs, 2);
        rst = 1'b0;
        #1;
        chk("t5b_async_out_valid", out_valid, 0);
        chk("t5b_async_out_last", out_last, 0);
        chk("t5b_async_busy", busy, 0);
        chk("t5b_async_sel", sel, 0);
        chk("t5b_async_dataIn", dataIn, 0);
        exp_out_q.delete();
        @(posedge clk); #1 rst = 1'b1;
        send_batch(4'd4, 4'd3, 4'd2, 4'd1, 0, 1'b1);
        wait_batch(400);

        // Stale done with garbage results present before the batch starts.
        @(posedge clk); #1 m_preset = 1'b1;
        @(posedge clk); #1 m_preset = 1'b0;
        send_batch(4'd6, 4'd5, 4'd11, 4'd2, 0, 1'b1);
        wait_batch(400);
        chk("t6_idle_after", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
